// File: rtl/regfile_dump_ctrl_pkg.sv
// Shared definitions for the register-file dump controller and the register file it borrows from.
// REGFILE_DUMP_HEADER_EN (see regfile_dump_ctrl.sv) enables the ST_HEADER path.
package regfile_dump_ctrl_pkg;

  localparam int NUM_REGS_DEF   = 32;
  localparam int ADDR_W_DEF     = 5;
  localparam int DATA_W_DEF     = 32;
  localparam int BYTES_PER_WORD = DATA_W_DEF / 8;

  localparam logic [7:0] HEADER_BYTE = 8'hA5;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_HEADER = 3'd1,
    ST_SETUP  = 3'd2,
    ST_SEND   = 3'd3,
    ST_DONE   = 3'd4
  } state_e;

  // Counter width able to hold 0..bpw, so the post-increment after the last byte never wraps.
  function automatic int byte_cnt_width(input int bpw);
    return (bpw < 1) ? 1 : $clog2(bpw + 1);
  endfunction

endpackage

// File: rtl/regfile_dump_ctrl_if.sv
// Register-file rs read port plus byte stream toward the debug UART TX.
// master = dump controller side, slave = pipeline / register file / UART side.
interface regfile_dump_ctrl_if
  import regfile_dump_ctrl_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) ();

  logic [ADDR_W-1:0] pipe_rs_sel;
  logic [ADDR_W-1:0] rf_rs_sel;
  logic [DATA_W-1:0] rf_rs_data;
  logic [7:0]        tx_data;
  logic              tx_valid;
  logic              tx_ready;

  modport master (
    input  pipe_rs_sel,
    input  rf_rs_data,
    input  tx_ready,
    output rf_rs_sel,
    output tx_data,
    output tx_valid
  );

  modport slave (
    output pipe_rs_sel,
    output rf_rs_data,
    output tx_ready,
    input  rf_rs_sel,
    input  tx_data,
    input  tx_valid
  );

endinterface

// File: rtl/regfile_dump_ctrl_serializer.sv
// Loads a parallel word (or a single stand-alone byte) and shifts it out LSB first
// over an 8-bit valid/ready stream; o_last marks the byte currently presented as the final one.
module word_byte_serializer
  import regfile_dump_ctrl_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_load,
  input  logic              i_load_byte,
  input  logic [DATA_W-1:0] i_word,
  input  logic [7:0]        i_byte,
  input  logic              i_ready,
  output logic [7:0]        o_data,
  output logic              o_valid,
  output logic              o_last,
  output logic              o_xfer
);

  localparam int BPW   = DATA_W / 8;
  localparam int CNT_W = byte_cnt_width(BPW);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BPW - 1);

  logic [DATA_W-1:0] r_shift;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_valid;
  logic              r_single;
  logic              w_xfer;
  logic              w_last;

  assign w_xfer  = r_valid & i_ready;
  assign w_last  = r_single | (r_cnt == LAST_CNT);
  assign o_data  = r_shift[7:0];
  assign o_valid = r_valid;
  assign o_last  = w_last;
  assign o_xfer  = w_xfer;

  // Shift register, byte counter and valid flag; a stalled byte holds all three.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_shift  <= '0;
      r_cnt    <= '0;
      r_valid  <= 1'b0;
      r_single <= 1'b0;
    end else if (i_load) begin
      r_shift  <= i_word;
      r_cnt    <= '0;
      r_valid  <= 1'b1;
      r_single <= 1'b0;
    end else if (i_load_byte) begin
      r_shift  <= DATA_W'(i_byte);
      r_cnt    <= '0;
      r_valid  <= 1'b1;
      r_single <= 1'b1;
    end else if (w_xfer) begin
      r_shift <= r_shift >> 8;
      r_cnt   <= r_cnt + CNT_W'(1);
      if (w_last) begin
        r_valid  <= 1'b0;
        r_single <= 1'b0;
      end else begin
        r_valid  <= 1'b1;
        r_single <= r_single;
      end
    end else begin
      r_shift  <= r_shift;
      r_cnt    <= r_cnt;
      r_valid  <= r_valid;
      r_single <= r_single;
    end
  end

endmodule

// File: rtl/regfile_dump_ctrl.sv
// Debug dump sequencer: borrows the register-file rs port and streams every register out LSB first.
// Define REGFILE_DUMP_HEADER_EN to prefix the stream with a single HEADER_BYTE.
module regfile_dump_ctrl
  import regfile_dump_ctrl_pkg::*;
#(
  parameter int NUM_REGS = NUM_REGS_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int DATA_W   = DATA_W_DEF
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_start,
  regfile_dump_ctrl_if.master bus,
  output logic                o_busy,
  output logic                o_done
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

  state_e            r_state;
  logic [ADDR_W-1:0] r_idx;
  logic              r_busy;
  logic              r_done;

  logic              w_load;
  logic              w_load_byte;
  logic              w_xfer;
  logic              w_last;

  // Pipeline owns the read port whenever no dump is running.
  assign bus.rf_rs_sel = r_busy ? r_idx : bus.pipe_rs_sel;

  assign w_load = (r_state == ST_SETUP);
`ifdef REGFILE_DUMP_HEADER_EN
  assign w_load_byte = (r_state == ST_IDLE) & i_start;
`else
  assign w_load_byte = 1'b0;
`endif

  word_byte_serializer #(
    .DATA_W (DATA_W)
  ) u_ser (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_load      (w_load),
    .i_load_byte (w_load_byte),
    .i_word      (bus.rf_rs_data),
    .i_byte      (HEADER_BYTE),
    .i_ready     (bus.tx_ready),
    .o_data      (bus.tx_data),
    .o_valid     (bus.tx_valid),
    .o_last      (w_last),
    .o_xfer      (w_xfer)
  );

  // Dump sequencer: state, register index and the registered busy/done outputs.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
      r_idx   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (i_start) begin
            r_idx  <= '0;
            r_busy <= 1'b1;
`ifdef REGFILE_DUMP_HEADER_EN
            r_state <= ST_HEADER;
`else
            r_state <= ST_SETUP;
`endif
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_HEADER: begin
          if (w_xfer) begin
            r_state <= ST_SETUP;
          end else begin
            r_state <= ST_HEADER;
          end
        end
        ST_SETUP: begin
          r_state <= ST_SEND;
        end
        ST_SEND: begin
          if (w_xfer && w_last) begin
            if (r_idx == LAST_IDX) begin
              r_state <= ST_DONE;
              r_done  <= 1'b1;
            end else begin
              r_idx   <= r_idx + ADDR_W'(1);
              r_state <= ST_SETUP;
            end
          end else begin
            r_state <= ST_SEND;
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
          r_idx   <= '0;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= ST_IDLE;
          r_idx   <= '0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign o_busy = r_busy;
  assign o_done = r_done;

endmodule

// File: tb/tb_regfile_dump_ctrl.sv
// Directed self-checking bench for regfile_dump_ctrl with a behavioural register file.
module tb_regfile_dump_ctrl;

`ifdef REGFILE_DUMP_HEADER_EN
  localparam int HDR = 1;
`else
  localparam int HDR = 0;
`endif
  localparam int NREG   = 32;
  localparam int NBYTES = NREG * 4 + HDR;

  logic clk;
  logic rst;
  logic start;
  logic busy;
  logic done;
  logic [31:0] regs [0:NREG-1];
  logic [7:0]  q [$];
  int checks;
  int failures;

  regfile_dump_ctrl_if bus ();

  assign bus.rf_rs_data = regs[bus.rf_rs_sel];

  regfile_dump_ctrl dut (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_start (start),
    .bus     (bus),
    .o_busy  (busy),
    .o_done  (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!rst && bus.tx_valid === 1'b1 && bus.tx_ready === 1'b1) q.push_back(bus.tx_data);
  end

  function automatic logic [7:0] exp_byte(input int k);
    logic [31:0] w;
    int kk;
`ifdef REGFILE_DUMP_HEADER_EN
    if (k == 0) return 8'hA5;
`endif
    kk = k - HDR;
    w  = regs[kk / 4] >> (8 * (kk % 4));
    return w[7:0];
  endfunction

  function automatic int stream_errs();
    int e = 0;
    for (int k = 0; k < q.size(); k++) if (q[k] !== exp_byte(k)) e++;
    return e;
  endfunction

  task automatic run_dump(input bit toggle, input int hold_at, input int start_again_at,
                          input bit start_in_done, output int done_cyc, output int done_cnt,
                          output int after_busy, output int stalls, output int stall_errs,
                          output int sel_errs);
    logic [7:0] pdata;
    bit pstall;
    bit held;
    int hold;
    int e;
    q.delete();
    done_cyc = 0; done_cnt = 0; after_busy = 0; stalls = 0; stall_errs = 0; sel_errs = 0;
    pstall = 1'b0; held = 1'b0; hold = 0; pdata = 8'h00;
    bus.tx_ready = 1'b1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int n = 1; n <= 3000; n++) begin
      if (pstall && (bus.tx_valid !== 1'b1 || bus.tx_data !== pdata)) stall_errs++;
      if (done_cyc != 0 && busy !== 1'b0) after_busy++;
      if (done === 1'b1) begin
        done_cnt++;
        if (done_cyc == 0) done_cyc = n;
        if (start_in_done) start = 1'b1;
      end
      if (n == start_again_at) start = 1'b1;
      if (hold > 0) begin
        bus.tx_ready = 1'b0;
        hold--;
      end else if (!held && hold_at >= 0 && q.size() == hold_at && bus.tx_valid === 1'b1) begin
        bus.tx_ready = 1'b0;
        held = 1'b1;
        hold = 9;
      end else if (toggle) begin
        bus.tx_ready = n[0];
      end else begin
        bus.tx_ready = 1'b1;
      end
      pstall = (bus.tx_valid === 1'b1) && (bus.tx_ready === 1'b0);
      if (pstall) stalls++;
      pdata = bus.tx_data;
      bus.pipe_rs_sel = 5'($urandom_range(0, 31));
      #1;
      if (busy === 1'b1) begin
        e = (int'(q.size()) - HDR) / 4;
        if (e < 0) e = 0;
        if (e > NREG - 1) e = NREG - 1;
        if (bus.rf_rs_sel !== 5'(e)) sel_errs++;
      end
      @(posedge clk); #1;
      start = 1'b0;
      if (done_cyc != 0 && n >= done_cyc + 8) break;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; bus.tx_ready = 1'b1; bus.pipe_rs_sel = 5'd3;
    repeat (3) @(posedge clk);
    #1;
    if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++;
    if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
    checks++;
    if (bus.tx_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", bus.tx_valid); end
    checks++;
    if (bus.tx_data !== 8'h00) begin failures++; $display("FAIL reset_data got=%h exp=00", bus.tx_data); end
    checks++;
    if (bus.rf_rs_sel !== 5'd3) begin failures++; $display("FAIL reset_sel got=%0d exp=3", bus.rf_rs_sel); end
    checks++;
    rst = 1'b0;
    @(posedge clk); #1;
    if (busy !== 1'b0) begin failures++; $display("FAIL idle_busy got=%b exp=0", busy); end
    checks++;
  endtask

  task automatic test_full_dump();
    int dc, dn, ab, st, se, sl;
    run_dump(1'b0, -1, -1, 1'b0, dc, dn, ab, st, se, sl);
    if (dc !== 161 + HDR) begin failures++; $display("FAIL full_done_cycle got=%0d exp=%0d", dc, 161 + HDR); end
    checks++;
    if (dn !== 1) begin failures++; $display("FAIL full_done_count got=%0d exp=1", dn); end
    checks++;
    if (ab !== 0) begin failures++; $display("FAIL full_busy_after got=%0d exp=0", ab); end
    checks++;
    if (q.size() !== NBYTES) begin failures++; $display("FAIL full_len got=%0d exp=%0d", q.size(), NBYTES); end
    checks++;
    if (stream_errs() !== 0) begin failures++; $display("FAIL full_stream got=%0d bad bytes exp=0", stream_errs()); end
    checks++;
`ifdef REGFILE_DUMP_HEADER_EN
    if (q[0] !== 8'hA5) begin failures++; $display("FAIL full_header got=%h exp=a5", q[0]); end
    checks++;
`endif
    if (q[HDR+0] !== 8'h00) begin failures++; $display("FAIL full_b0 got=%h exp=00", q[HDR+0]); end
    checks++;
    if (q[HDR+4] !== 8'h44) begin failures++; $display("FAIL full_b4 got=%h exp=44", q[HDR+4]); end
    checks++;
    if (q[HDR+5] !== 8'h33) begin failures++; $display("FAIL full_b5 got=%h exp=33", q[HDR+5]); end
    checks++;
    if (q[HDR+7] !== 8'h11) begin failures++; $display("FAIL full_b7 got=%h exp=11", q[HDR+7]); end
    checks++;
    if (q[HDR+124] !== 8'hEF) begin failures++; $display("FAIL full_b124 got=%h exp=ef", q[HDR+124]); end
    checks++;
    if (q[HDR+127] !== 8'hDE) begin failures++; $display("FAIL full_b127 got=%h exp=de", q[HDR+127]); end
    checks++;
  endtask

  task automatic test_port_sharing();
    int dc, dn, ab, st, se, sl;
    bus.pipe_rs_sel = 5'd7;
    #1;
    if (bus.rf_rs_sel !== 5'd7) begin failures++; $display("FAIL port_idle7 got=%0d exp=7", bus.rf_rs_sel); end
    checks++;
    bus.pipe_rs_sel = 5'd20;
    #1;
    if (bus.rf_rs_sel !== 5'd20) begin failures++; $display("FAIL port_idle20 got=%0d exp=20", bus.rf_rs_sel); end
    checks++;
    @(posedge clk); #1;
    run_dump(1'b0, -1, -1, 1'b0, dc, dn, ab, st, se, sl);
    if (sl !== 0) begin failures++; $display("FAIL port_busy_sel got=%0d bad cycles exp=0", sl); end
    checks++;
  endtask

  task automatic test_backpressure();
    int dc, dn, ab, st, se, sl;
    run_dump(1'b1, 42 + HDR, -1, 1'b0, dc, dn, ab, st, se, sl);
    if (se !== 0) begin failures++; $display("FAIL bp_stall_stable got=%0d bad cycles exp=0", se); end
    checks++;
    if (q.size() !== NBYTES) begin failures++; $display("FAIL bp_len got=%0d exp=%0d", q.size(), NBYTES); end
    checks++;
    if (stream_errs() !== 0) begin failures++; $display("FAIL bp_stream got=%0d bad bytes exp=0", stream_errs()); end
    checks++;
    if (dc !== 161 + HDR + st) begin failures++; $display("FAIL bp_done_cycle got=%0d exp=%0d", dc, 161 + HDR + st); end
    checks++;
    if (st < 10) begin failures++; $display("FAIL bp_stalls got=%0d exp>=10", st); end
    checks++;
    if (dn !== 1) begin failures++; $display("FAIL bp_done_count got=%0d exp=1", dn); end
    checks++;
    if (sl !== 0) begin failures++; $display("FAIL bp_sel got=%0d bad cycles exp=0", sl); end
    checks++;
  endtask

  task automatic test_start_while_busy();
    int dc, dn, ab, st, se, sl;
    run_dump(1'b0, -1, 50, 1'b1, dc, dn, ab, st, se, sl);
    if (dc !== 161 + HDR) begin failures++; $display("FAIL sb_done_cycle got=%0d exp=%0d", dc, 161 + HDR); end
    checks++;
    if (dn !== 1) begin failures++; $display("FAIL sb_done_count got=%0d exp=1", dn); end
    checks++;
    if (ab !== 0) begin failures++; $display("FAIL sb_restart got=%0d busy cycles exp=0", ab); end
    checks++;
    if (q.size() !== NBYTES) begin failures++; $display("FAIL sb_len got=%0d exp=%0d", q.size(), NBYTES); end
    checks++;
    if (stream_errs() !== 0) begin failures++; $display("FAIL sb_stream got=%0d bad bytes exp=0", stream_errs()); end
    checks++;
  endtask

  task automatic test_reset_mid();
    int dc, dn, ab, st, se, sl;
    int bad;
    bit found;
    regs[10] = 32'h0A0B0C0D;
    q.delete();
    found = 1'b0;
    bus.tx_ready = 1'b1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int n = 0; n < 400; n++) begin
      if (q.size() == 42 + HDR && bus.tx_valid === 1'b1) begin
        found = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    if (!found) begin failures++; $display("FAIL rst_reach_r10 got=timeout exp=r10 byte2"); end
    checks++;
    if (bus.tx_data !== 8'h0B) begin failures++; $display("FAIL rst_r10b2 got=%h exp=0b", bus.tx_data); end
    checks++;
    rst = 1'b1;
    bus.tx_ready = 1'b0;
    bus.pipe_rs_sel = 5'd9;
    @(posedge clk); #1;
    if (busy !== 1'b0) begin failures++; $display("FAIL rst_busy got=%b exp=0", busy); end
    checks++;
    if (bus.tx_valid !== 1'b0) begin failures++; $display("FAIL rst_valid got=%b exp=0", bus.tx_valid); end
    checks++;
    if (bus.rf_rs_sel !== 5'd9) begin failures++; $display("FAIL rst_sel got=%0d exp=9", bus.rf_rs_sel); end
    checks++;
    bad = 0;
    if (done !== 1'b0) bad++;
    rst = 1'b0;
    bus.tx_ready = 1'b1;
    repeat (5) begin
      @(posedge clk); #1;
      if (done !== 1'b0 || busy !== 1'b0) bad++;
    end
    if (bad !== 0) begin failures++; $display("FAIL rst_no_done got=%0d bad cycles exp=0", bad); end
    checks++;
    run_dump(1'b0, -1, -1, 1'b0, dc, dn, ab, st, se, sl);
    if (q.size() !== NBYTES) begin failures++; $display("FAIL rst_restart_len got=%0d exp=%0d", q.size(), NBYTES); end
    checks++;
    if (stream_errs() !== 0) begin failures++; $display("FAIL rst_restart_stream got=%0d bad bytes exp=0", stream_errs()); end
    checks++;
    if (dc !== 161 + HDR) begin failures++; $display("FAIL rst_restart_done got=%0d exp=%0d", dc, 161 + HDR); end
    checks++;
  endtask

  initial begin
    checks = 0;
    failures = 0;
    for (int i = 0; i < NREG; i++) regs[i] = 32'h0;
    regs[1]  = 32'h11223344;
    regs[31] = 32'hDEADBEEF;
    start = 1'b0;
    rst = 1'b1;
    bus.tx_ready = 1'b1;
    bus.pipe_rs_sel = 5'd0;
    test_reset();
    test_full_dump();
    test_port_sharing();
    test_backpressure();
    test_start_while_busy();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/regfile_dump_ctrl.md
Name: regfile_dump_ctrl

Overview:
Debug-side controller that shares the register file's rs read port between the pipeline and a debug dump sequencer. On a start request it takes over the read port. It walks every architectural register from index 0 to NUM_REGS-1 and serializes each 32-bit value into bytes over a valid/ready stream toward the debug UART TX. While it runs it holds the pipeline halted. When idle, the read port passes straight through to the pipeline.

Parameters:
NUM_REGS, 32, number of registers dumped (indices 0..NUM_REGS-1)
ADDR_W, 5, register select width; must satisfy 2**ADDR_W >= NUM_REGS
DATA_W, 32, register width; must be a multiple of 8

Ports:
i_clk  in  1  clock; all state updates on rising edge
i_rst  in  1  reset, synchronous, active-high
i_start  in  1  dump request; sampled only in IDLE
i_pipe_rs_sel  in  ADDR_W  pipeline's rs select
o_rf_rs_sel  out  ADDR_W  rs select driven to the register file
i_rf_rs_data  in  DATA_W  rs read data from the register file (combinational read)
o_tx_data  out  8  byte to UART TX
o_tx_valid  out  1  byte valid
i_tx_ready  in  1  UART TX accepts byte
o_busy  out  1  dump in progress; drives pipeline halt
o_done  out  1  single-cycle pulse at dump completion

Behaviour:
- Reset values: state=IDLE, idx=0, byte_cnt=0, shift=0, o_tx_valid=0, o_tx_data=0, o_busy=0, o_done=0.
- Read-port mux:
  - o_rf_rs_sel = i_pipe_rs_sel when o_busy=0.
  - o_rf_rs_sel = idx when o_busy=1.
  - The mux is purely combinational.
- o_busy=1 in every state except IDLE. It is registered and derived from the state.
- FSM states: IDLE, SETUP, SEND, DONE.
  - IDLE: if i_start=1, go to SETUP with idx=0.
  - SETUP (1 cycle): o_rf_rs_sel=idx. At the clock edge, shift<=i_rf_rs_data, byte_cnt<=0, then go to SEND.
  - SEND:
    - o_tx_valid=1 and o_tx_data=shift[7:0].
    - A byte transfers on a cycle with o_tx_valid&i_tx_ready. On transfer: shift>>=8, byte_cnt++.
    - After the transfer of byte DATA_W/8-1: if idx==NUM_REGS-1 go to DONE; otherwise idx++ and go to SETUP.
  - DONE (1 cycle): o_done=1, then go to IDLE with idx=0.
- Byte order: LSB first per register; registers in ascending index order.
- Stream length is NUM_REGS*DATA_W/8 bytes (128 by default).
- Register 0 dumps as 0x00 bytes, as supplied by the register file. No special casing in this block.
- Backpressure: while i_tx_ready=0 in SEND, o_tx_valid stays 1, and o_tx_data, idx and byte_cnt remain stable.
- o_tx_valid=0 in IDLE, SETUP and DONE.
- i_start while not IDLE, including in DONE, is ignored and not queued.
- i_rst asserted mid-dump: on the next edge return to reset values. Any partially sent register is abandoned. o_busy drops and o_done is not pulsed.
- Timing, default parameters with i_tx_ready held at 1:
  - 5 cycles per register (1 SETUP + 4 SEND), 160 cycles total.
  - o_done is high in cycle 161 after the edge that sampled i_start.

Optional Feature:
Macro REGFILE_DUMP_HEADER_EN.
- Defined: adds a HEADER state between IDLE and the first SETUP. HEADER presents byte 0xA5 with o_tx_valid=1 and holds until the handshake completes. Stream length becomes 129 bytes, and o_done moves one cycle later when ready is held at 1.
- Not defined: no HEADER state; the stream starts directly with r0 byte 0.

Decomposition:
- Shared package holds:
  - state enum (IDLE, HEADER, SETUP, SEND, DONE)
  - HEADER_BYTE=8'hA5
  - BYTES_PER_WORD=DATA_W/8
  - the ADDR_W/DATA_W defaults, shared with the register file
- One natural sub-module: word_byte_serializer. It takes a parallel load, drives the 8-bit valid/ready output, and flags the last byte. The top level keeps the FSM, the index counter and the port mux.

Test Plan:
1. Full dump with ready tied high:
   - Stimulus: preload r1=0x11223344, r31=0xDEADBEEF, others 0; pulse i_start.
   - Required: 128 bytes. Bytes 0-3 are 00, bytes 4-7 are 44 33 22 11, bytes 124-127 are EF BE AD DE. o_done pulses in cycle 161 and o_busy is low the cycle after.
2. Backpressure:
   - Stimulus: toggle i_tx_ready 1/0 every cycle during the dump; hold it low for 10 cycles mid-register.
   - Required: o_tx_data and o_tx_valid stay stable while stalled. The byte sequence is identical to test 1, and the completion time grows accordingly.
3. Port sharing:
   - Stimulus: idle with i_pipe_rs_sel=7.
   - Required: o_rf_rs_sel=7. During the dump, o_rf_rs_sel equals the current idx regardless of i_pipe_rs_sel.
4. Start while busy:
   - Stimulus: pulse i_start at cycle 50 of a dump and again in the DONE cycle.
   - Required: no restart and exactly one 128-byte stream.
5. Reset mid-dump:
   - Stimulus: assert i_rst during SEND of r10 byte 2.
   - Required: on the next edge o_busy=0, o_tx_valid=0, o_rf_rs_sel follows the pipeline, and no o_done. A new i_start restarts from r0 byte 0.
6. With REGFILE_DUMP_HEADER_EN defined:
   - Stimulus: repeat test 1.
   - Required: first byte 0xA5, then the same 128 bytes, 129 in total. o_done pulses in cycle 162.
